multicycle_ctrl: RTL and testbench

//  Control FSM for the multicycle RV32I core: sequences shared ALU, memory port, register file
//  and immediate extender (drives extender ImmSrc) per instruction phase. Moore main FSM plus

---
 rtl/multicycle_ctrl_pkg.sv | 58 +++++
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl_alu_dec.sv | 38 +++
 rtl/multicycle_ctrl.sv | 123 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module : riscv_ctrl_pkg
// Brief  : Shared encodings for the multicycle RV32I control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } statetype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_B:    return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module : multicycle_ctrl_if
// Brief  : Datapath <-> controller signal bundle for the multicycle core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic [2:0] ImmSrc;
  logic       Illegal;

  modport master (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, RegWrite, ImmSrc, Illegal
  );

  modport slave (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, RegWrite, ImmSrc, Illegal
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_alu_dec.sv
// ============================================================================
// Module : alu_dec
// Brief  : Maps ALUOp / funct3 / funct7b5 to the ALU operation select.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, which has no subtract form
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Moore control FSM for the multicycle RV32I core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  multicycle_ctrl_if.slave  ctrl
);

  statetype   state_q, state_d;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    w_alu_op       = ALUOP_ADD;
    ctrl.PCWrite   = 1'b0;
    ctrl.AdrSrc    = 1'b0;
    ctrl.MemWrite  = 1'b0;
    ctrl.IRWrite   = 1'b0;
    ctrl.ResultSrc = 2'b00;
    ctrl.ALUSrcA   = 2'b00;
    ctrl.ALUSrcB   = 2'b00;
    ctrl.RegWrite  = 1'b0;
    ctrl.Illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        ctrl.ALUSrcB   = 2'b10;
        ctrl.ResultSrc = 2'b10;
        ctrl.IRWrite   = ctrl.MemReady;
        ctrl.PCWrite   = ctrl.MemReady;
        if (ctrl.MemReady) state_d = DECODE;
      end
      DECODE: begin
        ctrl.ALUSrcA = 2'b01;
        ctrl.ALUSrcB = 2'b01;
        case (ctrl.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_B:         state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ctrl.ALUSrcA = 2'b10;
        ctrl.ALUSrcB = 2'b01;
        state_d      = (ctrl.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        ctrl.AdrSrc = 1'b1;
        if (ctrl.MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        ctrl.ResultSrc = 2'b01;
        ctrl.RegWrite  = 1'b1;
        state_d        = FETCH;
      end
      MEMWRITE: begin
        ctrl.AdrSrc   = 1'b1;
        ctrl.MemWrite = 1'b1;
        if (ctrl.MemReady) state_d = FETCH;
      end
      EXECR: begin
        ctrl.ALUSrcA = 2'b10;
        w_alu_op     = ALUOP_FUNCT;
        state_d      = ALUWB;
      end
      EXECI: begin
        ctrl.ALUSrcA = 2'b10;
        ctrl.ALUSrcB = 2'b01;
        w_alu_op     = ALUOP_FUNCT;
        state_d      = ALUWB;
      end
      ALUWB: begin
        ctrl.RegWrite = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        // funct3[0] flips the taken sense: beq takes on Zero, bne on !Zero
        ctrl.ALUSrcA = 2'b10;
        w_alu_op     = ALUOP_SUB;
        ctrl.PCWrite = ctrl.Zero ^ ctrl.funct3[0];
        state_d      = (ctrl.funct3[2:1] == 2'b00) ? FETCH : TRAP;
      end
      JAL: begin
        ctrl.ALUSrcA = 2'b01;
        ctrl.ALUSrcB = 2'b10;
        ctrl.PCWrite = 1'b1;
        state_d      = ALUWB;
      end
      TRAP: begin
        ctrl.Illegal = 1'b1;
        state_d      = TRAP;
      end
      default: state_d = FETCH;
    endcase
  end

  assign ctrl.ImmSrc = imm_src(ctrl.op);

  alu_dec u_alu_dec (
    .alu_op      (w_alu_op),
    .funct3      (ctrl.funct3),
    .op5         (ctrl.op[5]),
    .funct7b5    (ctrl.funct7b5),
    .alu_control (ctrl.ALUControl)
  );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Random instruction stream against a per-phase expected-output list.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if cif ();

  multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (cif)
  );

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        mr;
    logic        zero;
    logic [17:0] v;
  } ent_t;

  ent_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] c_op;
  logic [2:0] c_f3;
  logic       c_f7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] imm_exp(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      default:    return 3'b000;
    endcase
  endfunction

  // Expected output bundle: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,SrcA,SrcB,ALUControl,RegWrite,Illegal,ImmSrc}
  function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, rw, ill, imm_exp(c_op)};
  endfunction

  function automatic logic [17:0] obs();
    return {cif.PCWrite, cif.AdrSrc, cif.MemWrite, cif.IRWrite, cif.ResultSrc, cif.ALUSrcA,
            cif.ALUSrcB, cif.ALUControl, cif.RegWrite, cif.Illegal, cif.ImmSrc};
  endfunction

  function automatic logic [17:0] fetch_idle();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
  endfunction

  // ALU operation an R/I instruction should execute with
  function automatic logic [2:0] alu_exp();
    logic is_r;
    is_r = (c_op == 7'b0110011);
    case (c_f3)
      3'b000:  return (is_r && c_f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic mr, input logic zero, input logic [17:0] v);
    ent_t e;
    e.op = c_op; e.f3 = c_f3; e.f7 = c_f7; e.mr = mr; e.zero = zero; e.v = v;
    q.push_back(e);
  endtask

  task automatic push_fetch_decode(input int stalls);
    repeat (stalls) push(1'b0, rb(), fetch_idle());
    push(1'b1, rb(), ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0));
    push(rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0));
  endtask

  task automatic push_memadr();
    push(rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0));
  endtask

  task automatic push_aluwb();
    push(rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
  endtask

  task automatic push_trap(input int n);
    repeat (n) push(rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1));
  endtask

  // Builds the whole cycle list of one instruction; returns 1 if it ends in the trap
  task automatic build(input int fst, input int mst, input logic bz, output logic trapped);
    logic [17:0] v;
    trapped = 1'b0;
    push_fetch_decode(fst);
    case (c_op)
      7'b0000011: begin
        push_memadr();
        v = ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        repeat (mst) push(1'b0, rb(), v);
        push(1'b1, rb(), v);
        push(rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
      end
      7'b0100011: begin
        push_memadr();
        v = ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        repeat (mst) push(1'b0, rb(), v);
        push(1'b1, rb(), v);
      end
      7'b0110011, 7'b0010011: begin
        push(rb(), rb(), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                            (c_op == 7'b0010011) ? 2'b01 : 2'b00, alu_exp(), 1'b0, 1'b0));
        push_aluwb();
      end
      7'b1100011: begin
        push(rb(), bz, ev(bz ^ c_f3[0], 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0, 1'b0));
        trapped = (c_f3 > 3'd1);
      end
      7'b1101111: begin
        push(rb(), rb(), ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0));
        push_aluwb();
      end
      default: trapped = 1'b1;
    endcase
  endtask

  task automatic run_q();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      cif.op = e.op; cif.funct3 = e.f3; cif.funct7b5 = e.f7;
      cif.MemReady = e.mr; cif.Zero = e.zero;
      #1;
      check($sformatf("op%b_f3%b", e.op, e.f3), 32'(obs()), 32'(e.v));
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    cif.MemReady = 1'b0;
    reset_n = 1'b0;
    #1;
    check(tag, 32'(obs()), 32'(fetch_idle()));
    #2 reset_n = 1'b1;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input int fst, input int mst, input logic bz, input int trap_cyc);
    logic t;
    c_op = op; c_f3 = f3; c_f7 = f7;
    build(fst, mst, bz, t);
    if (t) push_trap(trap_cyc);
    run_q();
    if (t) reset_pulse("trap_reset");
  endtask

  initial begin
    logic [6:0] rop;
    int         k;
    reset_n = 1'b0;
    c_op = 7'b0010011; c_f3 = 3'b000; c_f7 = 1'b0;
    cif.op = c_op; cif.funct3 = c_f3; cif.funct7b5 = c_f7;
    cif.MemReady = 1'b0; cif.Zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset", 32'(obs()), 32'(fetch_idle()));
    reset_n = 1'b1;

    do_instr(7'b0010011, 3'b000, 1'b0, 0, 0, 1'b0, 0);   // addi x8,x9,12
    do_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0, 0);   // sub
    do_instr(7'b0110011, 3'b010, 1'b0, 0, 0, 1'b0, 0);   // slt
    do_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0, 0);   // lw, 3 memory stalls
    do_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, 0);   // beq taken
    do_instr(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b1, 0);   // bne not taken
    do_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 10);  // illegal opcode

    // sw interrupted by reset while the write strobe is up
    c_op = 7'b0100011; c_f3 = 3'b010; c_f7 = 1'b0;
    push_fetch_decode(0);
    push_memadr();
    run_q();
    @(negedge clk);
    cif.MemReady = 1'b0;
    #1;
    check("memwrite", 32'(obs()),
          32'(ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0)));
    reset_n = 1'b0;
    #1;
    check("memwrite_async_rst", 32'(obs()), 32'(fetch_idle()));
    #1 reset_n = 1'b1;

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 12);
      case (k)
        0, 1:  rop = 7'b0000011;
        2, 3:  rop = 7'b0100011;
        4, 5:  rop = 7'b0110011;
        6, 7:  rop = 7'b0010011;
        8, 9:  rop = 7'b1100011;
        10:    rop = 7'b1101111;
        11: begin
          do rop = 7'($urandom);
          while (rop inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b1101111});
        end
        default: rop = 7'b1100011;
      endcase
      do_instr(rop, (k == 8 || k == 9) ? {2'b00, rb()} : 3'($urandom), rb(),
               $urandom_range(0, 2), $urandom_range(0, 3), rb(), $urandom_range(2, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
